matrix_scan: RTL
================

MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter COLS, default 32: columns per panel row (SHIFT phase length).
REQ-002 Parameter DISPLAY_CYCLES, default 256: clk cycles per row with OEN low.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 screen  input  6  screen select from the screen mux; sampled once per frame.
REQ-006 rom_addr  output  15  {screen_q[5:0], row[3:0], col[4:0]} to external synchronous pattern ROM.
REQ-007 rom_data  input  6  {r1,g1,b1,r2,g2,b2} for rom_addr; valid one clk after rom_addr.
REQ-008 r1, g1, b1  output  1 each  upper-half pixel colour, registered.
REQ-009 r2, g2, b2  output  1 each  lower-half pixel colour, registered.
REQ-010 A, B, C, D  output  1 each  row address of the displayed row pair (A = LSB).
REQ-011 LAT  output  1  latch strobe, active high.
REQ-012 OEN  output  1  output enable, active low.
REQ-013 OCLK  output  1  shift clock; panel samples colour on the rising edge.
REQ-014 frame_done  output  1  one-clk pulse at the end of each frame.

Function
REQ-015 State machine SHALL have states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-016 IDLE lasts 1 cycle, then goes to SHIFT with row=0; screen_q <= screen on that edge.
REQ-017 SHIFT SHALL last 2*COLS+2 cycles, indexed k=0..2*COLS+1 from entry.
- rom_addr col field = k/2 for k<2*COLS.
- RGB registers load rom_data so that column c's data is on the colour outputs in cycles 2c+2 and 2c+3.
REQ-018 OCLK SHALL be high only in SHIFT cycles 2c+3 (c=0..COLS-1): exactly COLS rising edges per row, each with colour already stable for 1 clk.
REQ-019 After SHIFT: BLANK for 1 cycle, then LATCH for 1 cycle.
- LATCH: LAT=1, and {D,C,B,A} <= row on that edge.
- LAT SHALL be 0 in every other state.
REQ-020 DISPLAY lasts DISPLAY_CYCLES cycles with OEN=0; OEN SHALL be 1 in every other state.
REQ-021 Row period SHALL be 2*COLS+4+DISPLAY_CYCLES cycles (324 at defaults).
REQ-022 End of DISPLAY with row<15: row <= row+1, go to SHIFT.
REQ-023 End of DISPLAY with row=15:
- row wraps to 0; screen_q <= screen; frame_done=1 for exactly the next cycle; go to SHIFT.
- Frame = 16*324 = 5184 cycles at defaults.
REQ-024 Changes on screen mid-frame SHALL NOT affect rom_addr until the next frame boundary (no tearing).
REQ-025 Colour outputs SHALL hold their last value outside SHIFT.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, row=0, col=0, screen_q=0;
- OEN=1, LAT=0, OCLK=0, frame_done=0;
- all colour outputs and A-D = 0.
REQ-027 Assertion mid-row, including during DISPLAY, SHALL blank the panel at once (OEN=1). After release, operation restarts from IDLE with row 0.

Verification
REQ-028 Reset: screen=5, release reset -> 1 IDLE cycle, then rom_addr={6'd5,4'd0,5'd0}, OEN=1, OCLK=0.
REQ-029 Shift: ROM model returns rom_data = col[5:0] -> exactly 32 OCLK rising edges; colour at edge c equals c[5:0]; no OCLK edge outside SHIFT.
REQ-030 Latch/display: after row 3 SHIFT -> 1 BLANK cycle, LAT=1 for one cycle with {D,C,B,A}=3, then OEN=0 for exactly 256 cycles.
REQ-031 Screen change: screen 3->7 during row 5 -> rom_addr[14:9]=3 through row 15, =7 from the next row 0; frame_done pulses once, 5184 cycles after the first SHIFT.
REQ-032 Async reset mid-DISPLAY (row 9, cycle 100) -> OEN=1 before the next clk edge; after release, rows resume from 0.

Source files
------------

// File: rtl/matrix_scan.sv
`default_nettype none
// =============================================================================
// matrix_scan : 1/16-scan RGB LED panel row scanner fed by a pattern ROM
// Revision    : 1.0
// =============================================================================
module matrix_scan #(
  parameter int COLS           = 32,
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  screen,
  output logic [14:0] rom_addr,
  input  logic [5:0]  rom_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        LAT,
  output logic        OEN,
  output logic        OCLK,
  output logic        frame_done
);

  localparam int SHIFT_LEN = 2 * COLS + 2;
  localparam int CNT_MAX   = (SHIFT_LEN > DISPLAY_CYCLES) ? SHIFT_LEN : DISPLAY_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST     = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] SHIFT_DATA_END = CNT_W'(2 * COLS);
  localparam logic [CNT_W-1:0] OCLK_FIRST     = CNT_W'(3);
  localparam logic [CNT_W-1:0] DISP_LAST      = CNT_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_q, row_d;
  logic [5:0]       screen_q, screen_d;
  logic [5:0]       rgb_q, rgb_d;
  logic [3:0]       addr_q, addr_d;
  logic             lat_q, lat_d;
  logic             oen_q, oen_d;
  logic             oclk_q, oclk_d;
  logic             fd_q, fd_d;

  logic [CNT_W-1:0] half_cnt;
  logic [4:0]       col_field;

  // Each column is addressed for two cycles so the ROM latency hides behind the pair.
  always_comb begin
    half_cnt  = cnt_q >> 1;
    col_field = 5'd0;
    if (state_q == SHIFT && cnt_q < SHIFT_DATA_END) begin
      col_field = 5'(half_cnt);
    end
  end

  assign rom_addr = {screen_q, row_q, col_field};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    screen_d = screen_q;
    rgb_d    = rgb_q;
    addr_d   = addr_q;
    fd_d     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d  = SHIFT;
        cnt_d    = '0;
        row_d    = 4'd0;
        screen_d = screen;
      end
      SHIFT: begin
        // ROM data for the column addressed on an even cycle arrives on the odd one.
        if (cnt_q[0] && cnt_q < SHIFT_DATA_END) begin
          rgb_d = rom_data;
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        if (cnt_q == DISP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          if (row_q == 4'd15) begin
            row_d    = 4'd0;
            screen_d = screen;
            fd_d     = 1'b1;
          end else begin
            row_d = row_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == LATCH) begin
      addr_d = row_q;
    end
    lat_d  = (state_d == LATCH);
    oen_d  = (state_d != DISPLAY);
    // Rising shift clock sits in the second cycle of each colour pair.
    oclk_d = (state_d == SHIFT) && cnt_d[0] && (cnt_d >= OCLK_FIRST) && (cnt_d <= SHIFT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= 4'd0;
      screen_q <= 6'd0;
      rgb_q    <= 6'd0;
      addr_q   <= 4'd0;
      lat_q    <= 1'b0;
      oen_q    <= 1'b1;
      oclk_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      screen_q <= screen_d;
      rgb_q    <= rgb_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      oen_q    <= oen_d;
      oclk_q   <= oclk_d;
      fd_q     <= fd_d;
    end
  end

  assign {r1, g1, b1, r2, g2, b2} = rgb_q;
  assign {D, C, B, A}             = addr_q;
  assign LAT                      = lat_q;
  assign OEN                      = oen_q;
  assign OCLK                     = oclk_q;
  assign frame_done               = fd_q;

endmodule
`default_nettype wire
